fft_quad_frame_ctrl: RTL

Frame sequencer in front of the four-phase FFT datapath (`fft_quad`). It aligns the free-running ADC sample strobe to frame boundaries after a sync pulse and forwards whole frames only when every FFT core is ready and timestamp buffering is available. It generates the frame `valid`/`last` for the FFT inputs and supplies one timestamp per admitted frame on the AXI-Stream port that `fft_quad` pops at each output-frame `m_last`. Status counters expose started, dropped and completed frames.

---
 rtl/fft_quad_pkg.sv | 27 ++
 rtl/fft_quad_frame_ctrl_if.sv | 47 ++++
 rtl/fft_ts_fifo.sv | 67 ++++++
 rtl/fft_quad_frame_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_quad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_quad_pkg
// Description : Shared types and constants for the fft_quad frame sequencer
//               and its timestamp FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_quad_pkg;

    // Timestamp width carried alongside each FFT frame
    localparam int c_TS_W          = 32;

    // Default geometry: samples per channel per frame, frames in flight
    localparam int c_FRAME_LEN_DEF = 4096;
    localparam int c_TS_DEPTH_DEF  = 4;

    // Frame controller states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fft_quad_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_quad_frame_ctrl_if
// Description : FFT input stream and frame-timestamp AXI-Stream bundle
//               between the frame controller (master) and fft_quad (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_quad_frame_ctrl_if #(
    parameter int DATA_W = 120
) ();

    // FFT sample stream
    logic                             fft_valid;
    logic                             fft_last;
    logic [DATA_W-1:0]                fft_data;
    logic                             fft_ready;

    // Per-frame timestamp stream
    logic [fft_quad_pkg::c_TS_W-1:0]  m_axis_ts_tdata;
    logic                             m_axis_ts_tvalid;
    logic                             m_axis_ts_tready;
    logic                             m_axis_ts_tlast;

    modport master (
        output fft_valid,
        output fft_last,
        output fft_data,
        input  fft_ready,
        output m_axis_ts_tdata,
        output m_axis_ts_tvalid,
        input  m_axis_ts_tready,
        output m_axis_ts_tlast
    );

    modport slave (
        input  fft_valid,
        input  fft_last,
        input  fft_data,
        output fft_ready,
        input  m_axis_ts_tdata,
        input  m_axis_ts_tvalid,
        output m_axis_ts_tready,
        input  m_axis_ts_tlast
    );

endinterface
`default_nettype wire

// File: rtl/fft_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fft_ts_fifo
// Description : Synchronous first-word-fall-through FIFO for frame
//               timestamps. Read data shows the head entry whenever not
//               empty and reads as zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_ts_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop  & ~o_empty;
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

    // Storage write; contents need no reset since reads are gated by empty
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_quad_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_quad_frame_ctrl
// Description : Frame sequencer in front of fft_quad. Aligns the ADC strobe
//               to frame boundaries after sync, admits whole frames only when
//               the FFT cores are ready and a timestamp slot is free, and
//               keeps started/dropped/completed frame counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_quad_frame_ctrl
    import fft_quad_pkg::*;
#(
    parameter int FRAME_LEN = c_FRAME_LEN_DEF,
    parameter int DATA_W    = 120,
    parameter int TS_DEPTH  = c_TS_DEPTH_DEF,
    parameter int CNT_W     = 32
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    input  wire logic                enable,
    input  wire logic                sync,
    input  wire logic                adc_valid,
    input  wire logic [DATA_W-1:0]   adc_data,
    input  wire logic [c_TS_W-1:0]   ts_now,
    fft_quad_frame_ctrl_if.master    bus,
    output logic                     busy,
    output logic [CNT_W-1:0]         frames_started,
    output logic [CNT_W-1:0]         frames_dropped,
    output logic [CNT_W-1:0]         frames_done,
    output logic                     stall_err,
    output logic                     ts_underflow
);

    localparam int c_CW = $clog2(FRAME_LEN);

    state_t            r_state;
    state_t            w_next_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_CW-1:0]   w_cnt_next;
    logic              w_fwd;
    logic              w_last;
    logic              w_push;
    logic              w_drop;
    logic              w_stall;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    logic              r_fft_valid;
    logic              r_fft_last;
    logic [DATA_W-1:0] r_fft_data;
    logic [CNT_W-1:0]  r_started;
    logic [CNT_W-1:0]  r_dropped;
    logic [CNT_W-1:0]  r_done;
    logic              r_stall_err;
    logic              r_underflow;

    // Timestamp storage: one entry per admitted frame, popped by fft_quad
    fft_ts_fifo #(
        .DEPTH (TS_DEPTH),
        .WIDTH (c_TS_W)
    ) u_ts_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_wdata (ts_now),
        .i_pop   (w_pop),
        .o_rdata (bus.m_axis_ts_tdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign bus.m_axis_ts_tvalid = ~w_empty;
    assign bus.m_axis_ts_tlast  = ~w_empty;
    assign w_pop                = ~w_empty & bus.m_axis_ts_tready;

    // State and sample counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, admission check and per-sample strobes
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_fwd        = 1'b0;
        w_last       = 1'b0;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end else if (sync) begin
                    w_next_state = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (!enable) begin
                    w_next_state = ST_IDLE;
                end else if (adc_valid) begin
                    w_cnt_next = c_CW'(1);
                    // Occupancy is taken as-is: a pop this cycle frees no slot
                    if (bus.fft_ready && !w_full) begin
                        w_fwd        = 1'b1;
                        w_push       = 1'b1;
                        w_next_state = ST_ACTIVE;
                    end else begin
                        w_drop       = 1'b1;
                        w_next_state = ST_SKIP;
                    end
                end
            end
            ST_ACTIVE, ST_SKIP: begin
                if (adc_valid) begin
                    w_fwd   = (r_state == ST_ACTIVE);
                    w_stall = (r_state == ST_ACTIVE) & ~bus.fft_ready;
                    if (r_cnt == c_CW'(FRAME_LEN-1)) begin
                        // Frame boundary is the only point enable is honoured
                        w_last       = 1'b1;
                        w_cnt_next   = '0;
                        w_next_state = enable ? ST_WAIT0 : ST_IDLE;
                    end else begin
                        w_cnt_next   = r_cnt + c_CW'(1);
                    end
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Registered FFT input stream
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_fft_valid <= 1'b0;
            r_fft_last  <= 1'b0;
            r_fft_data  <= '0;
        end else begin
            r_fft_valid <= w_fwd;
            r_fft_last  <= w_fwd & w_last;
            if (w_fwd) begin
                r_fft_data <= adc_data;
            end
        end
    end

    // Status counters (wrapping) and sticky error flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_started   <= '0;
            r_dropped   <= '0;
            r_done      <= '0;
            r_stall_err <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_started <= r_started + CNT_W'(1);
            end
            if (w_drop) begin
                r_dropped <= r_dropped + CNT_W'(1);
            end
            if (w_pop) begin
                r_done <= r_done + CNT_W'(1);
            end
            if (w_stall) begin
                r_stall_err <= 1'b1;
            end
            if (w_empty && bus.m_axis_ts_tready) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign bus.fft_valid  = r_fft_valid;
    assign bus.fft_last   = r_fft_last;
    assign bus.fft_data   = r_fft_data;
    assign busy           = (r_state != ST_IDLE);
    assign frames_started = r_started;
    assign frames_dropped = r_dropped;
    assign frames_done    = r_done;
    assign stall_err      = r_stall_err;
    assign ts_underflow   = r_underflow;

endmodule
`default_nettype wire
